// File: rtl/wb_ctrl_master.sv
// wb_ctrl_master: self-running Wishbone B3 classic single-beat bus exerciser.
// After reset it writes a pass-stamped pattern to NUM_WORDS consecutive words,
// reads the block back and compares, then pauses and repeats forever.
// Mismatches and ack timeouts are reported on sticky flags; pass_o counts
// completed write/read passes.

module wb_ctrl_master #(
   parameter int unsigned STARTUP_CYCLES = 32,      // idle edges after reset before first strobe
   parameter int unsigned NUM_WORDS      = 8,       // words per pass (1..1024)
   parameter logic [11:0] BASE_ADR       = 12'h000, // byte address of word 0
   parameter int unsigned GAP_CYCLES     = 1,       // idle cycles between transactions (>=1)
   parameter int unsigned PAUSE_CYCLES   = 16,      // extra idle cycles between passes (>=1)
   parameter int unsigned TIMEOUT        = 255      // strobe cycles allowed before giving up
) (
   input  logic        clk50,
   input  logic        arst_n,
   output logic [11:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        wb_cyc_o,
   output logic        err_o,
   output logic        timeout_o,
   output logic [15:0] pass_o
);

   // ------------------------------------------------------------------
   // Sizing
   // ------------------------------------------------------------------
   localparam int unsigned WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned CNT_W  = 16;

   localparam logic [WORD_W-1:0] LAST_WORD    = WORD_W'(NUM_WORDS - 1);
   localparam logic [CNT_W-1:0]  STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]  PAUSE_LAST   = CNT_W'(PAUSE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TMO_LAST     = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_WAIT,    // startup delay after reset
      S_WR,      // write strobe for word_q
      S_WR_GAP,  // idle between writes
      S_RD,      // read strobe for word_q
      S_RD_GAP,  // idle between reads
      S_PAUSE    // idle between passes
   } state_t;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;      // delay counter, or strobe-cycle counter while strobing
   logic [WORD_W-1:0] word_q, word_d;    // word index within the pass
   logic [15:0]       pass_q, pass_d;    // completed pass count

   // Next values of the registered bus/status outputs
   logic [11:0] adr_d;
   logic [31:0] dat_d;
   logic        we_d;
   logic [3:0]  sel_d;
   logic        stb_d;
   logic        err_d;
   logic        tmo_d;

   // Strobe-phase events
   logic        strobing;
   logic        acked;
   logic        timed_out;
   logic [31:0] expected;

   // A transaction ends either on ack or when the strobe has been up TIMEOUT cycles.
   // Ack outside a strobe is ignored because strobing gates it.
   assign strobing  = (state_q == S_WR) || (state_q == S_RD);
   assign acked     = strobing && wb_ack_i;
   assign timed_out = strobing && !wb_ack_i && (cnt_q == TMO_LAST);

   // Read-back reference: the pattern written to this address in this pass.
   assign expected  = {pass_q, 4'h0, wb_adr_o};

   // Byte address of a word index, wrapping mod 4096.
   function automatic logic [11:0] word_adr(input logic [WORD_W-1:0] idx);
      return BASE_ADR + 12'({idx, 2'b00});
   endfunction

   // State register: FSM state, counters and pass count.
   // NOTE: sequential state always uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk50 or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= S_WAIT;
         cnt_q   <= '0;
         word_q  <= '0;
         pass_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         pass_q  <= pass_d;
      end
   end

   // Next-state logic: sequencing through write block, read block and pause.
   // NOTE: every variable gets a default at the top of the comb block so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      word_d  = word_q;
      pass_d  = pass_q;

      unique case (state_q)
         S_WAIT: begin
            if (cnt_q == STARTUP_LAST) begin
               state_d = S_WR;
               cnt_d   = '0;
               word_d  = '0;
            end
         end

         S_WR: begin
            if (acked || timed_out) begin
               state_d = S_WR_GAP;
               cnt_d   = '0;
            end
         end

         S_WR_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (word_q == LAST_WORD) begin
                  state_d = S_RD;
                  word_d  = '0;
               end else begin
                  state_d = S_WR;
                  word_d  = word_q + 1'b1;
               end
            end
         end

         S_RD: begin
            if (acked || timed_out) begin
               state_d = S_RD_GAP;
               cnt_d   = '0;
            end
         end

         S_RD_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (word_q == LAST_WORD) begin
                  // Pass complete: count it as we enter the pause.
                  state_d = S_PAUSE;
                  word_d  = '0;
                  pass_d  = pass_q + 16'd1;
               end else begin
                  state_d = S_RD;
                  word_d  = word_q + 1'b1;
               end
            end
         end

         S_PAUSE: begin
            if (cnt_q == PAUSE_LAST) begin
               state_d = S_WR;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = S_WAIT;
            cnt_d   = '0;
            word_d  = '0;
         end
      endcase
   end

   // Output logic: next bus values derived from the next state, plus sticky flags.
   always_comb begin
      adr_d = wb_adr_o;        // address holds after a transaction ends
      dat_d = '0;
      we_d  = 1'b0;
      sel_d = 4'h0;
      stb_d = 1'b0;
      err_d = err_o;
      tmo_d = timeout_o | timed_out;

      // Compare only genuinely acked reads; a timed-out read has no data.
      if ((state_q == S_RD) && acked && (wb_dat_i != expected)) begin
         err_d = 1'b1;
      end

      if (state_d == S_WR) begin
         stb_d = 1'b1;
         we_d  = 1'b1;
         sel_d = 4'hF;
         adr_d = word_adr(word_d);
         dat_d = {pass_d, 4'h0, word_adr(word_d)};
      end else if (state_d == S_RD) begin
         stb_d = 1'b1;
         sel_d = 4'hF;
         adr_d = word_adr(word_d);
      end
   end

   // Output register: all bus and status outputs come straight from flops.
   always_ff @(posedge clk50 or negedge arst_n) begin
      if (!arst_n) begin
         wb_adr_o  <= '0;
         wb_dat_o  <= '0;
         wb_we_o   <= 1'b0;
         wb_sel_o  <= '0;
         wb_stb_o  <= 1'b0;
         wb_cyc_o  <= 1'b0;
         err_o     <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         wb_adr_o  <= adr_d;
         wb_dat_o  <= dat_d;
         wb_we_o   <= we_d;
         wb_sel_o  <= sel_d;
         wb_stb_o  <= stb_d;
         wb_cyc_o  <= stb_d;   // single-beat: cycle and strobe are identical
         err_o     <= err_d;
         timeout_o <= tmo_d;
      end
   end

   assign pass_o = pass_q;

endmodule

// File: tb/tb_wb_ctrl_master.sv
// Directed testbench for wb_ctrl_master with default parameters.
// A small registered memory slave answers strobes after a configurable delay;
// it can also return zero on reads or never acknowledge.

module tb_wb_ctrl_master;

   logic        clk50 = 1'b0;
   logic        arst_n = 1'b0;
   logic [11:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_ack_i;
   logic        wb_cyc_o;
   logic        err_o;
   logic        timeout_o;
   logic [15:0] pass_o;

   // Slave model controls
   int          ack_delay = 3;
   logic        rd_zero   = 1'b0;
   logic        no_ack    = 1'b0;
   logic        spur_ack  = 1'b0;

   logic        slv_ack;
   logic [31:0] slv_dat;
   logic [31:0] mem [0:7];
   int          lat;

   int n_checks = 0;
   int n_fail   = 0;

   assign wb_ack_i = slv_ack | spur_ack;
   assign wb_dat_i = slv_dat;

   always #10 clk50 = ~clk50;

   wb_ctrl_master dut (
      .clk50     (clk50),
      .arst_n    (arst_n),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_dat_i  (wb_dat_i),
      .wb_we_o   (wb_we_o),
      .wb_sel_o  (wb_sel_o),
      .wb_stb_o  (wb_stb_o),
      .wb_ack_i  (wb_ack_i),
      .wb_cyc_o  (wb_cyc_o),
      .err_o     (err_o),
      .timeout_o (timeout_o),
      .pass_o    (pass_o)
   );

   // Registered memory slave: acks ack_delay+1 edges after it first sees stb.
   always @(posedge clk50 or negedge arst_n) begin
      if (!arst_n) begin
         slv_ack <= 1'b0;
         slv_dat <= '0;
         lat     <= 0;
      end else begin
         slv_ack <= 1'b0;
         if (wb_stb_o && !slv_ack && !no_ack) begin
            if (lat == ack_delay) begin
               slv_ack <= 1'b1;
               lat     <= 0;
               if (wb_we_o) mem[wb_adr_o[4:2]] <= wb_dat_o;
               else         slv_dat <= rd_zero ? 32'h0 : mem[wb_adr_o[4:2]];
            end else begin
               lat <= lat + 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 ns later.
   task automatic step();
      @(posedge clk50);
      #1;
   endtask

   // kind 0: strobe high, 1: read acked, 2: pass_o==1, 3: write acked, 4: read strobe
   function automatic bit cond(input int kind);
      case (kind)
         0: return wb_stb_o;
         1: return wb_stb_o && !wb_we_o && wb_ack_i;
         2: return pass_o == 16'd1;
         3: return wb_stb_o && wb_we_o && wb_ack_i;
         default: return wb_stb_o && !wb_we_o;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int kind, input int max_cycles);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         step();
         if (cond(kind)) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, {31'b0, ok}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk50);
      arst_n = 1'b0;
      repeat (2) @(negedge clk50);
      arst_n = 1'b1;
   endtask

   initial begin
      int n_hi;
      bit early_tmo;

      // ---- reset state ----
      #5;
      check("rst_stb", {31'b0, wb_stb_o}, 32'd0);
      check("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
      check("rst_we",  {31'b0, wb_we_o},  32'd0);
      check("rst_sel", {28'b0, wb_sel_o}, 32'd0);
      check("rst_adr", {20'b0, wb_adr_o}, 32'd0);
      check("rst_dat", wb_dat_o, 32'd0);
      check("rst_err", {31'b0, err_o}, 32'd0);
      check("rst_tmo", {31'b0, timeout_o}, 32'd0);
      check("rst_pass", {16'b0, pass_o}, 32'd0);

      // ---- startup delay, with a spurious ack pulse during WAIT ----
      @(negedge clk50);
      arst_n = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         step();
         if (i == 10) spur_ack = 1'b1;
         if (i == 11) spur_ack = 1'b0;
         if (i == 31) begin
            check("wait_stb31", {31'b0, wb_stb_o}, 32'd0);
            check("wait_adr31", {20'b0, wb_adr_o}, 32'd0);
            check("wait_err31", {31'b0, err_o}, 32'd0);
         end
      end
      check("wr0_stb", {31'b0, wb_stb_o}, 32'd1);
      check("wr0_cyc", {31'b0, wb_cyc_o}, 32'd1);
      check("wr0_we",  {31'b0, wb_we_o},  32'd1);
      check("wr0_sel", {28'b0, wb_sel_o}, 32'hF);
      check("wr0_adr", {20'b0, wb_adr_o}, 32'h000);
      check("wr0_dat", wb_dat_o, 32'h0000_0000);

      // ---- ack ends the strobe on the same edge, next write after GAP ----
      wait_for("wr0_ack_seen", 3, 20);
      step();
      check("wr0_drop_stb", {31'b0, wb_stb_o}, 32'd0);
      check("wr0_drop_cyc", {31'b0, wb_cyc_o}, 32'd0);
      check("wr0_drop_we",  {31'b0, wb_we_o},  32'd0);
      check("wr0_drop_sel", {28'b0, wb_sel_o}, 32'd0);
      check("wr0_hold_adr", {20'b0, wb_adr_o}, 32'h000);
      step();
      check("wr1_stb", {31'b0, wb_stb_o}, 32'd1);
      check("wr1_we",  {31'b0, wb_we_o},  32'd1);
      check("wr1_adr", {20'b0, wb_adr_o}, 32'h004);
      check("wr1_dat", wb_dat_o, 32'h0000_0004);

      // ---- full pass against memory slave ----
      wait_for("pass1_seen", 2, 600);
      check("pass1_err", {31'b0, err_o}, 32'd0);
      check("pass1_tmo", {31'b0, timeout_o}, 32'd0);
      check("pass1_cnt", {16'b0, pass_o}, 32'd1);
      check("mem0", mem[0], 32'h0000_0000);
      check("mem7", mem[7], 32'h0000_001C);

      // ---- pause between passes, with a spurious ack pulse ----
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i == 5) spur_ack = 1'b1;
         if (i == 6) spur_ack = 1'b0;
         if (i == 15) check("pause_stb15", {31'b0, wb_stb_o}, 32'd0);
      end
      check("p1wr0_stb", {31'b0, wb_stb_o}, 32'd1);
      check("p1wr0_adr", {20'b0, wb_adr_o}, 32'h000);
      check("p1wr0_dat", wb_dat_o, 32'h0001_0000);
      check("pause_err", {31'b0, err_o}, 32'd0);
      wait_for("p1wr0_ack_seen", 3, 20);
      step();
      step();
      check("p1wr1_adr", {20'b0, wb_adr_o}, 32'h004);
      check("p1wr1_dat", wb_dat_o, 32'h0001_0004);

      // ---- reads return zero: word 0 matches, word 1 sets err ----
      rd_zero = 1'b1;
      do_reset();
      wait_for("rz_rd0_seen", 1, 300);
      step();
      check("rz_rd0_adr", {20'b0, wb_adr_o}, 32'h000);
      check("rz_rd0_err", {31'b0, err_o}, 32'd0);
      wait_for("rz_rd1_seen", 1, 40);
      step();
      check("rz_rd1_adr", {20'b0, wb_adr_o}, 32'h004);
      check("rz_rd1_err", {31'b0, err_o}, 32'd1);
      wait_for("rz_pass_seen", 2, 300);
      check("rz_err_sticky", {31'b0, err_o}, 32'd1);
      rd_zero = 1'b0;

      // ---- slave never acks: timeout after 255 strobe cycles ----
      no_ack = 1'b1;
      do_reset();
      wait_for("to_stb_seen", 0, 40);
      n_hi = 1;
      early_tmo = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (!wb_stb_o) break;
         if (timeout_o) early_tmo = 1'b1;
         n_hi++;
      end
      check("to_stb_len", n_hi, 32'd255);
      check("to_early", {31'b0, early_tmo}, 32'd0);
      check("to_flag", {31'b0, timeout_o}, 32'd1);
      check("to_we_low", {31'b0, wb_we_o}, 32'd0);
      check("to_hold_adr", {20'b0, wb_adr_o}, 32'h000);
      step();
      check("to_next_stb", {31'b0, wb_stb_o}, 32'd1);
      check("to_next_adr", {20'b0, wb_adr_o}, 32'h004);
      no_ack = 1'b0;

      // ---- reset asserted during a read strobe ----
      do_reset();
      wait_for("ar_rd_seen", 4, 300);
      arst_n = 1'b0;
      #2;
      check("ar_stb", {31'b0, wb_stb_o}, 32'd0);
      check("ar_cyc", {31'b0, wb_cyc_o}, 32'd0);
      check("ar_we",  {31'b0, wb_we_o},  32'd0);
      check("ar_adr", {20'b0, wb_adr_o}, 32'd0);
      @(negedge clk50);
      arst_n = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         step();
         if (i == 31) check("ar_stb31", {31'b0, wb_stb_o}, 32'd0);
      end
      check("ar_wr0_stb", {31'b0, wb_stb_o}, 32'd1);
      check("ar_wr0_we",  {31'b0, wb_we_o},  32'd1);
      check("ar_wr0_adr", {20'b0, wb_adr_o}, 32'h000);
      check("ar_wr0_dat", wb_dat_o, 32'h0000_0000);
      check("ar_pass", {16'b0, pass_o}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
